instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Responder end of the IQ_2_IR interface. Accepts decoded control words and RVFI words pushed by the instruction decode/fetch stage.
- Buffers them in an in-order circular FIFO.
- Presents the oldest entry to the dispatch stage (reservation stations / ROB) with a valid/ready handshake.
- Supports a full flush on branch mispredict or JALR redirect.

Parameters:
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), width of the head and tail pointers (derived; not overridden).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- iq_ir_itf  modport IQ_2_IR.IQ_SIG  -  carries ld_iq (in), control_word (in, tomasula_types::ctl_word) and rvfi (in, rv32i_types::rvfi_word)
- iq_ack  output  1  enqueue accepted this cycle
- flush_ip  input  1  flush in progress; empties the queue
- deq_ready  input  1  dispatch can take the head entry this cycle
- deq_valid  output  1  head entry valid
- deq_control_word  output  ctl_word  head entry control word
- deq_rvfi  output  rvfi_word  head entry rvfi word
- count  output  PTR_W+1  current occupancy
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Behaviour:
- Single clock domain. All state updates on posedge clk.
- Reset (synchronous, active-high): head=0, tail=0, count=0. Storage contents are don't-care.
- While rst is high: iq_ack=0, deq_valid=0, full=0, empty=1.
- Reset mid-operation discards all entries, including any enqueue or dequeue in that cycle.
- Enqueue handshake:
  - iq_ack is combinational: iq_ack = ld_iq & ~full & ~flush_ip & ~rst.
  - When iq_ack=1, the entry is written at tail and tail wraps DEPTH-1 -> 0.
  - The producer holds ld_iq and control_word stable until it sees iq_ack.
  - Exactly one entry is written per handshake. ld_iq held high after the ack cycle counts as a new request.
- Dequeue handshake:
  - deq_valid = ~empty.
  - deq_control_word and deq_rvfi are a combinational read of storage[head].
  - deq_fire = deq_valid & deq_ready & ~flush_ip. On deq_fire, head advances with wrap.
- Occupancy: count_next = count + enq - deq, where enq = iq_ack and deq = deq_fire. Simultaneous enq and deq leaves count unchanged.
- Full: no enqueue, even if a dequeue happens in the same cycle. This keeps deq_ready off the iq_ack path.
- Empty: no bypass. An entry written in cycle N is visible on deq_valid in cycle N+1, so minimum latency is 1 cycle.
- Flush:
  - While flush_ip=1, no enqueue and no dequeue.
  - On the next edge head=tail=0 and count=0.
  - Flush has priority over every other event in the same cycle.
  - Held flush_ip keeps the queue empty. Normal operation resumes the cycle after flush_ip deasserts.
- No state machine beyond the pointers and counter. Behaviour is fully defined by the enq/deq/flush/rst priority: rst > flush_ip > (enq, deq).

Optional Feature:
- Macro: IQ_RVFI_EN.
- Defined: each entry also stores the rvfi word, and deq_rvfi shows the head entry's rvfi word.
- Undefined: no rvfi storage is built and deq_rvfi is tied to '0. All other behaviour is identical.

Decomposition:
- Add iq_entry_t {ctl_word cw; rvfi_word rvfi;} to tomasula_types.
- Add an IQ_DEPTH_DEFAULT constant to the same package.
- One natural sub-module: iq_storage. It is a DEPTH x entry register array with one write port (wen, waddr, wdata) and one asynchronous read port (raddr -> rdata). No reset on the array.
- Pointer, counter, flush and handshake logic stays in instr_queue.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then ld_iq=0 -> count=0, empty=1, deq_valid=0, iq_ack=0.
- Fill to full (DEPTH=8): push 8 entries with og_pc 0x60,0x64,...,0x7C and deq_ready=0 -> iq_ack=1 on each push, full=1 after the 8th. A 9th ld_iq is held 3 cycles with iq_ack=0. Raising deq_ready pops 0x60, then iq_ack=1 on the next cycle.
- Order and wrap: push 12 and pop 12 interleaved with deq_ready toggling every cycle -> dequeued og_pc sequence 0x60..0x8C strictly in order, and the tail pointer wraps past 7.
- Simultaneous enq/deq at count=3 -> count stays 3. Head og_pc advances by one entry per pop.
- Flush: count=5, flush_ip=1 with ld_iq=1 and deq_ready=1 -> iq_ack=0 and no deq_fire. Next cycle count=0 and empty=1. After flush_ip drops, a push of og_pc 0x200 is the head one cycle later.
- Reset mid-operation: count=4, rst=1 while ld_iq=1 -> iq_ack=0. After release count=0 and deq_valid=0.
- With IQ_RVFI_EN undefined: deq_rvfi == 0 on every cycle of the fill test.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: RV32I-wide shared types.
//   rvfi_word - retirement/formal-interface record carried alongside each instruction.
package rv32i_types;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] inst;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
    } rvfi_word;

endpackage

// File: rtl/tomasula_types.sv
// tomasula_types: types shared by the out-of-order back end.
//   ctl_word         - decoded control word produced by decode
//   iq_entry_t       - one instruction-queue slot (control word + rvfi word)
//   IQ_DEPTH_DEFAULT - default instruction-queue depth
package tomasula_types;
    import rv32i_types::*;

    localparam int unsigned IQ_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic [31:0] og_pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } ctl_word;

    typedef struct packed {
        ctl_word  cw;
        rvfi_word rvfi;
    } iq_entry_t;

endpackage

// File: rtl/IQ_2_IR.sv
// IQ_2_IR: decode/fetch -> instruction queue push interface.
//   ld_iq        - push request (held until acknowledged)
//   control_word - decoded control word
//   rvfi         - rvfi word for the same instruction
// IQ_SIG is the queue (responder) view, IR_SIG the producer view.
interface IQ_2_IR;
    import tomasula_types::*;
    import rv32i_types::*;

    logic     ld_iq;
    ctl_word  control_word;
    rvfi_word rvfi;

    modport IQ_SIG (input ld_iq, input control_word, input rvfi);
    modport IR_SIG (output ld_iq, output control_word, output rvfi);
endinterface

// File: rtl/iq_storage.sv
// iq_storage: DEPTH-entry register array for the instruction queue.
//   clk            - clock
//   wen/waddr/wdata - single write port, written on posedge clk
//   raddr/rdata    - asynchronous read port
// No reset: contents are only meaningful between head and tail.
// Macro IQ_RVFI_EN: when defined the rvfi word is stored too; otherwise
// rdata.rvfi reads as zero and no rvfi flops exist.
module iq_storage
    import tomasula_types::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH_DEFAULT,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wen,
    input  logic [PTR_W-1:0] waddr,
    input  iq_entry_t        wdata,
    input  logic [PTR_W-1:0] raddr,
    output iq_entry_t        rdata
);

    ctl_word cw_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            cw_q[waddr] <= wdata.cw;
        end
    end

`ifdef IQ_RVFI_EN
    rv32i_types::rvfi_word rvfi_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            rvfi_q[waddr] <= wdata.rvfi;
        end
    end

    always_comb begin
        rdata.cw   = cw_q[raddr];
        rdata.rvfi = rvfi_q[raddr];
    end
`else
    // rvfi input is intentionally dropped in this build.
    logic unused_rvfi;
    assign unused_rvfi = ^wdata.rvfi;

    always_comb begin
        rdata.cw   = cw_q[raddr];
        rdata.rvfi = '0;
    end
`endif

endmodule

// File: rtl/instr_queue.sv
// instr_queue: in-order circular instruction queue between decode and dispatch.
//   clk, rst          - clock, synchronous active-high reset
//   iq_ir_itf         - push side (ld_iq, control_word, rvfi)
//   iq_ack            - push accepted this cycle (combinational)
//   flush_ip          - flush: drop everything, block push/pop
//   deq_ready         - dispatch takes the head this cycle
//   deq_valid         - head entry valid
//   deq_control_word  - head control word
//   deq_rvfi          - head rvfi word ('0 unless IQ_RVFI_EN is defined)
//   count/full/empty  - occupancy status
// Priority: rst > flush_ip > (enqueue, dequeue). No bypass: a pushed entry
// is visible at the head one cycle later.
module instr_queue
    import tomasula_types::*;
    import rv32i_types::*;
#(
    parameter  int unsigned DEPTH = IQ_DEPTH_DEFAULT,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    IQ_2_IR.IQ_SIG         iq_ir_itf,
    output logic           iq_ack,
    input  logic           flush_ip,
    input  logic           deq_ready,
    output logic           deq_valid,
    output ctl_word        deq_control_word,
    output rvfi_word       deq_rvfi,
    output logic [PTR_W:0] count,
    output logic           full,
    output logic           empty
);

    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             deq_fire;
    iq_entry_t        wr_entry;
    iq_entry_t        rd_entry;

    always_comb begin
        full      = ~rst & (count_q == FullCount);
        empty     = rst | (count_q == '0);
        // Full blocks push regardless of deq_ready so the ack never depends on dispatch.
        iq_ack    = iq_ir_itf.ld_iq & ~full & ~flush_ip & ~rst;
        deq_valid = ~empty;
        deq_fire  = deq_valid & deq_ready & ~flush_ip;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_ip) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (iq_ack) begin
                tail_d = tail_q + 1'b1;
            end
            if (deq_fire) begin
                head_d = head_q + 1'b1;
            end
            case ({iq_ack, deq_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        wr_entry.cw   = iq_ir_itf.control_word;
        wr_entry.rvfi = iq_ir_itf.rvfi;
    end

    iq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk   (clk),
        .wen   (iq_ack),
        .waddr (tail_q),
        .wdata (wr_entry),
        .raddr (head_q),
        .rdata (rd_entry)
    );

    assign deq_control_word = rd_entry.cw;
    assign deq_rvfi         = rd_entry.rvfi;
    assign count            = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// Directed testbench for instr_queue (DEPTH = 8).
// Inputs change on the falling edge; outputs are sampled #1 later.
module tb_instr_queue;
    import rv32i_types::*;
    import tomasula_types::*;

    localparam int unsigned DEPTH = 8;

    logic     clk = 1'b0;
    logic     rst;
    logic     flush_ip;
    logic     deq_ready;
    logic     iq_ack;
    logic     deq_valid;
    logic     full;
    logic     empty;
    ctl_word  deq_control_word;
    rvfi_word deq_rvfi;
    logic [3:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    IQ_2_IR iq_if ();

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .iq_ir_itf        (iq_if),
        .iq_ack           (iq_ack),
        .flush_ip         (flush_ip),
        .deq_ready        (deq_ready),
        .deq_valid        (deq_valid),
        .deq_control_word (deq_control_word),
        .deq_rvfi         (deq_rvfi),
        .count            (count),
        .full             (full),
        .empty            (empty)
    );

    always #5 clk = ~clk;

    function automatic ctl_word make_cw(input logic [31:0] pc);
        ctl_word c;
        c.og_pc  = pc;
        c.opcode = 7'h13;
        c.rd     = pc[6:2];
        c.rs1    = pc[11:7];
        c.rs2    = 5'd0;
        c.imm    = ~pc;
        return c;
    endfunction

    function automatic rvfi_word make_rvfi(input logic [31:0] pc);
        rvfi_word r;
        r.valid    = 1'b1;
        r.order    = {32'd0, pc};
        r.inst     = 32'h0000_0013;
        r.pc_rdata = pc;
        r.pc_wdata = pc + 32'd4;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_word(input logic [31:0] pc);
        iq_if.control_word = make_cw(pc);
        iq_if.rvfi         = make_rvfi(pc);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        flush_ip     = 1'b0;
        deq_ready    = 1'b0;
        iq_if.ld_iq  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_n(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            iq_if.ld_iq = 1'b1;
            drive_word(base + 32'(4 * i));
            tick();
        end
        iq_if.ld_iq = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        iq_if.ld_iq = 1'b1;
        drive_word(32'h10);
        #1;
        n_tests++;
        if (iq_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", iq_ack); end
        n_tests++;
        if (empty !== 1'b1 || full !== 1'b0 || deq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_flags: got empty=%b full=%b valid=%b want 1 0 0", empty, full, deq_valid);
        end
        tick();
        tick();
        rst         = 1'b0;
        iq_if.ld_iq = 1'b0;
        #1;
        n_tests++;
        if (count !== 4'd0 || empty !== 1'b1 || deq_valid !== 1'b0 || iq_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL idle: got count=%0d empty=%b valid=%b ack=%b want 0 1 0 0",
                     count, empty, deq_valid, iq_ack);
        end
        tick();
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            iq_if.ld_iq = 1'b1;
            drive_word(32'h60 + 32'(4 * i));
            #1;
            n_tests++;
            if (iq_ack !== 1'b1 || count !== 4'(i)) begin
                n_fail++;
                $display("FAIL fill_push%0d: got ack=%b count=%0d want 1 %0d", i, iq_ack, count, i);
            end
            n_tests++;
`ifdef IQ_RVFI_EN
            if (i > 0 && deq_rvfi.pc_rdata !== 32'h60) begin
                n_fail++;
                $display("FAIL fill_rvfi%0d: got %h want 60", i, deq_rvfi.pc_rdata);
            end
`else
            if (deq_rvfi !== '0) begin
                n_fail++;
                $display("FAIL fill_rvfi%0d: got %h want 0", i, deq_rvfi);
            end
`endif
            tick();
        end
        drive_word(32'h80);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (full !== 1'b1 || count !== 4'd8 || iq_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL full_hold%0d: got full=%b count=%0d ack=%b want 1 8 0",
                         i, full, count, iq_ack);
            end
            n_tests++;
`ifdef IQ_RVFI_EN
            if (deq_rvfi.pc_rdata !== 32'h60) begin
                n_fail++;
                $display("FAIL full_rvfi%0d: got %h want 60", i, deq_rvfi.pc_rdata);
            end
`else
            if (deq_rvfi !== '0) begin
                n_fail++;
                $display("FAIL full_rvfi%0d: got %h want 0", i, deq_rvfi);
            end
`endif
            tick();
        end
        deq_ready = 1'b1;
        #1;
        n_tests++;
        if (iq_ack !== 1'b0 || deq_valid !== 1'b1 || deq_control_word.og_pc !== 32'h60) begin
            n_fail++;
            $display("FAIL full_pop: got ack=%b valid=%b pc=%h want 0 1 60",
                     iq_ack, deq_valid, deq_control_word.og_pc);
        end
        tick();
        deq_ready = 1'b0;
        #1;
        n_tests++;
        if (count !== 4'd7 || iq_ack !== 1'b1 || deq_control_word.og_pc !== 32'h64) begin
            n_fail++;
            $display("FAIL after_pop: got count=%0d ack=%b pc=%h want 7 1 64",
                     count, iq_ack, deq_control_word.og_pc);
        end
        tick();
        iq_if.ld_iq = 1'b0;
        #1;
        n_tests++;
        if (count !== 4'd8 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL refill: got count=%0d full=%b want 8 1", count, full);
        end
    endtask

    task automatic test_order_wrap();
        logic [31:0] sb[$];
        logic [31:0] pc;
        logic        exp_ack;
        int          pushed = 0;
        int          popped = 0;
        int          cyc    = 0;
        do_reset();
        while (popped < 12 && cyc < 80) begin
            n_tests++;
            if (count !== 4'(sb.size()) || deq_valid !== (sb.size() > 0)) begin
                n_fail++;
                $display("FAIL wrap_occ c%0d: got count=%0d valid=%b want %0d", cyc, count,
                         deq_valid, sb.size());
            end
            pc          = 32'h60 + 32'(4 * pushed);
            iq_if.ld_iq = (pushed < 12);
            drive_word(pc);
            deq_ready   = (cyc % 2 == 1);
            #1;
            exp_ack = (pushed < 12) && (sb.size() < DEPTH);
            n_tests++;
            if (iq_ack !== exp_ack) begin
                n_fail++;
                $display("FAIL wrap_ack c%0d: got %b want %b", cyc, iq_ack, exp_ack);
            end
            if (deq_ready && sb.size() > 0) begin
                n_tests++;
                if (deq_control_word.og_pc !== sb[0]) begin
                    n_fail++;
                    $display("FAIL wrap_order c%0d: got %h want %h", cyc,
                             deq_control_word.og_pc, sb[0]);
                end
                void'(sb.pop_front());
                popped++;
            end
            if (exp_ack) begin
                sb.push_back(pc);
                pushed++;
            end
            tick();
            cyc++;
        end
        iq_if.ld_iq = 1'b0;
        deq_ready   = 1'b0;
        n_tests++;
        if (popped != 12 || pushed != 12) begin
            n_fail++;
            $display("FAIL wrap_done: got pushed=%0d popped=%0d want 12 12", pushed, popped);
        end
    endtask

    task automatic test_simul();
        do_reset();
        push_n(32'h100, 3);
        for (int i = 0; i < 2; i++) begin
            iq_if.ld_iq = 1'b1;
            drive_word(32'h10C + 32'(4 * i));
            deq_ready = 1'b1;
            #1;
            n_tests++;
            if (iq_ack !== 1'b1 || deq_control_word.og_pc !== 32'h100 + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL simul%0d: got ack=%b pc=%h want 1 %h", i, iq_ack,
                         deq_control_word.og_pc, 32'h100 + 32'(4 * i));
            end
            tick();
            iq_if.ld_iq = 1'b0;
            deq_ready   = 1'b0;
            #1;
            n_tests++;
            if (count !== 4'd3 || deq_control_word.og_pc !== 32'h104 + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL simul_cnt%0d: got count=%0d pc=%h want 3 %h", i, count,
                         deq_control_word.og_pc, 32'h104 + 32'(4 * i));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        do_reset();
        push_n(32'h300, 5);
        flush_ip    = 1'b1;
        iq_if.ld_iq = 1'b1;
        drive_word(32'h400);
        deq_ready   = 1'b1;
        #1;
        n_tests++;
        if (iq_ack !== 1'b0 || count !== 4'd5) begin
            n_fail++;
            $display("FAIL flush_ack: got ack=%b count=%0d want 0 5", iq_ack, count);
        end
        tick();
        #1;
        n_tests++;
        if (count !== 4'd0 || empty !== 1'b1 || iq_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_empty: got count=%0d empty=%b ack=%b want 0 1 0",
                     count, empty, iq_ack);
        end
        tick();
        flush_ip  = 1'b0;
        deq_ready = 1'b0;
        drive_word(32'h200);
        #1;
        n_tests++;
        if (count !== 4'd0 || iq_ack !== 1'b1 || deq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_resume: got count=%0d ack=%b valid=%b want 0 1 0",
                     count, iq_ack, deq_valid);
        end
        tick();
        iq_if.ld_iq = 1'b0;
        #1;
        n_tests++;
        if (deq_valid !== 1'b1 || count !== 4'd1 || deq_control_word.og_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL flush_head: got valid=%b count=%0d pc=%h want 1 1 200",
                     deq_valid, count, deq_control_word.og_pc);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_n(32'h500, 4);
        #1;
        n_tests++;
        if (count !== 4'd4) begin
            n_fail++;
            $display("FAIL mid_pre: got count=%0d want 4", count);
        end
        @(negedge clk);
        rst         = 1'b1;
        iq_if.ld_iq = 1'b1;
        deq_ready   = 1'b1;
        drive_word(32'h600);
        #1;
        n_tests++;
        if (iq_ack !== 1'b0 || deq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst: got ack=%b valid=%b want 0 0", iq_ack, deq_valid);
        end
        tick();
        rst         = 1'b0;
        iq_if.ld_iq = 1'b0;
        deq_ready   = 1'b0;
        #1;
        n_tests++;
        if (count !== 4'd0 || deq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_post: got count=%0d valid=%b want 0 0", count, deq_valid);
        end
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        flush_ip    = 1'b0;
        deq_ready   = 1'b0;
        iq_if.ld_iq = 1'b0;
        drive_word(32'h0);
        @(negedge clk);
        test_reset();
        test_fill();
        test_order_wrap();
        test_simul();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
